main_project: RTL and testbench
===============================

MAIN_PROJECT -- requirements
Module: main_project

Interface
REQ-001 Parameters (name, default, meaning): A0REG 0, B0REG 0 = first-stage A/B register present (1) or bypassed (0); A1REG 1, B1REG 1, CREG 1, DREG 1, MREG 1, PREG 1, CARRYINREG 1, CARRYOUTREG 1, OPMODEREG 1 = stage registered (1) or combinational (0); CARRYINSEL "OPMODE5" = carry source, "CARRYIN" selects port CARRYIN; B_INPUT "DIRECT" = B0 source, "CASCADE" selects BCIN.
REQ-002 CLK in 1: single clock; all registers update on its rising edge.
REQ-003 RST_N in 1: asynchronous, active-low global reset of every register.
REQ-004 RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE in 1 each: synchronous active-high clears for the matching register group.
REQ-005 CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE in 1 each: clock enables; a register holds its value when its CE is 0.
REQ-006 Data inputs: A in 18; B in 18; D in 18; BCIN in 18 (cascade B); C in 48; PCIN in 48 (cascade P); CARRYIN in 1; OPMODE in 8.
REQ-007 Outputs: M out 36 (multiplier result); P out 48; PCOUT out 48 (equals P); BCOUT out 18 (B1-stage output); CARRYOUT out 1; CARRYOUTF out 1 (equals CARRYOUT).

Function
REQ-008 Each stage SHALL be a register when its parameter is 1, or a wire when 0. Register priority: RST_N low, then sync RST*, then CE. All clears drive the register to 0.
REQ-009 OPMODE stage: OPMODE SHALL pass through the OPMODEREG stage (CEOPMODE/RSTOPMODE); all downstream selects SHALL use the staged value op.
REQ-010 Pre-adder: input D_r is D after the DREG stage; input B0 is the B/BCIN selection after the B0REG stage. If op[6]=0, result = D_r + B0; if op[6]=1, result = D_r - B0. Result width is 18 bits and wraps modulo 2^18.
REQ-011 B1 stage input: the pre-adder result if op[4]=1, else B0. It passes through the B1REG stage. BCOUT = B1 output.
REQ-012 A path: A passes through the A0REG stage, then the A1REG stage (both use CEA/RSTA). The result is A1.
REQ-013 Multiplier: unsigned A1 × B1 gives a 36-bit product, which passes through the MREG stage. M = MREG output.
REQ-014 X mux (op[1:0]):
- 0 → 0
- 1 → M zero-extended to 48 bits
- 2 → P
- 3 → {D_r[11:0], A1, B1}
REQ-015 Z mux (op[3:2]):
- 0 → 0
- 1 → PCIN
- 2 → P
- 3 → C after the CREG stage
REQ-016 Carry-in: source is op[5] or CARRYIN according to CARRYINSEL; it passes through the CARRYINREG stage (CECARRYIN/RSTCARRYIN) to give CIN.
REQ-017 Post-adder, computed at 49 bits:
- op[7]=0: Z + (X + CIN)
- op[7]=1: Z - (X + CIN)
Bits [47:0] pass through the PREG stage (CEP/RSTP) to P. Bit 48 (carry, or borrow when subtracting) passes through the CARRYOUTREG stage (CECARRYIN/RSTCARRYIN) to CARRYOUT.
REQ-018 Feedback selections (X=2, Z=2) SHALL use the current P register value, allowing accumulation every cycle.
REQ-019 Latency with default parameters and inputs held constant: P/CARRYOUT are valid 4 rising edges after the inputs are applied, via D → B1 → M → P. M is valid after 3 edges.
REQ-020 Post-adder overflow SHALL wrap modulo 2^48; only CARRYOUT flags it.

Reset
REQ-021 While RST_N=0, every register is 0 (asynchronously), so M=0, P=PCOUT=0, BCOUT=0, CARRYOUT=CARRYOUTF=0, regardless of CLK/CE.
REQ-022 A sync RST* asserted together with its CE=1 SHALL clear the register (reset wins). Asserting RST_N mid-accumulation SHALL zero P immediately; accumulation restarts from 0 after release.
REQ-023 With CE=0, a register SHALL keep its value, including across a toggling CLK.

Verification
REQ-024 RST_N=0 with random inputs and all CE=1 → all outputs 0. Release RST_N, but keep RSTP=1 → P stays 0.
REQ-025 A=2, B=3, D=4, C=5, OPMODE=0x1D, all CE=1 → after 4 edges M=14, P=19, CARRYOUT=0.
REQ-026 Same inputs, OPMODE=0x5D → M=2 (4-3=1, ×2), P=7.
REQ-027 Same inputs, OPMODE=0x9D → P=48'hFFFF_FFFF_FFF7 (5-14), CARRYOUT=1.
REQ-028 A=2, B=3, D=4, OPMODE=0x19 (accumulate), P starting at 0 → P increases by 14 every cycle after the pipeline fills. Dropping CEP to 0 freezes P.
REQ-029 OPMODE=0x0F, A=18'h3FFFF, B=1, D=18'h00ABC, C=0 → P={12'hABC, 18'h3FFFF, 18'h00001}. BCOUT=1.

Source files
------------

// File: rtl/main_project.sv
// rtl/main_project.sv - DSP slice with pre-adder, 18x18 multiplier and 48-bit post-adder

// Optional pipeline stage: a register with async clear, sync clear and enable, or a plain wire
module pipe_stage #(
    parameter int WIDTH   = 1,
    parameter bit USE_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (USE_REG) begin : g_reg
            logic [WIDTH-1:0] q_r;

            // Async clear wins, then the sync clear, then the enable
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_r <= '0;
                end else if (rst) begin
                    q_r <= '0;
                end else if (ce) begin
                    q_r <= d;
                end
            end

            assign q = q_r;
        end else begin : g_wire
            // Control pins are meaningless for a bypassed stage
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, ce, rst};
            assign q = d;
        end
    endgenerate

endmodule

// Top-level DSP slice
module main_project #(
    parameter bit    A0REG       = 1'b0,
    parameter bit    A1REG       = 1'b1,
    parameter bit    B0REG       = 1'b0,
    parameter bit    B1REG       = 1'b1,
    parameter bit    CREG        = 1'b1,
    parameter bit    DREG        = 1'b1,
    parameter bit    MREG        = 1'b1,
    parameter bit    PREG        = 1'b1,
    parameter bit    CARRYINREG  = 1'b1,
    parameter bit    CARRYOUTREG = 1'b1,
    parameter bit    OPMODEREG   = 1'b1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTCARRYIN,
    input  logic        RSTOPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CECARRYIN,
    input  logic        CEOPMODE,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] D,
    input  logic [17:0] BCIN,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic        CARRYIN,
    input  logic [7:0]  OPMODE,
    output logic [35:0] M,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic [17:0] BCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);

    localparam bit USE_CASCADE_B  = (B_INPUT == "CASCADE");
    localparam bit USE_CARRYIN_IN = (CARRYINSEL == "CARRYIN");

    logic [7:0]  op;
    logic [17:0] d_r;
    logic [17:0] b_src;
    logic [17:0] b0;
    logic [17:0] a0;
    logic [17:0] a1;
    logic [17:0] pre_sum;
    logic [17:0] b1_in;
    logic [17:0] b1;
    logic [47:0] c_r;
    logic [35:0] m_prod;
    logic [35:0] m_r;
    logic        cin_src;
    logic        cin;
    logic [47:0] x_mux;
    logic [47:0] z_mux;
    logic [48:0] x_plus_cin;
    logic [48:0] post_sum;
    logic [47:0] p_r;
    logic        cout_r;

    pipe_stage #(.WIDTH(8), .USE_REG(OPMODEREG)) u_op (
        .clk(CLK), .rst_n(RST_N), .ce(CEOPMODE), .rst(RSTOPMODE), .d(OPMODE), .q(op)
    );

    pipe_stage #(.WIDTH(18), .USE_REG(DREG)) u_d (
        .clk(CLK), .rst_n(RST_N), .ce(CED), .rst(RSTD), .d(D), .q(d_r)
    );

    assign b_src = USE_CASCADE_B ? BCIN : B;

    pipe_stage #(.WIDTH(18), .USE_REG(B0REG)) u_b0 (
        .clk(CLK), .rst_n(RST_N), .ce(CEB), .rst(RSTB), .d(b_src), .q(b0)
    );

    pipe_stage #(.WIDTH(18), .USE_REG(A0REG)) u_a0 (
        .clk(CLK), .rst_n(RST_N), .ce(CEA), .rst(RSTA), .d(A), .q(a0)
    );

    pipe_stage #(.WIDTH(18), .USE_REG(A1REG)) u_a1 (
        .clk(CLK), .rst_n(RST_N), .ce(CEA), .rst(RSTA), .d(a0), .q(a1)
    );

    // Pre-adder on D and B0 (wraps at 18 bits), optionally feeding the B1 stage
    always_comb begin
        pre_sum = op[6] ? (d_r - b0) : (d_r + b0);
        b1_in   = op[4] ? pre_sum : b0;
    end

    pipe_stage #(.WIDTH(18), .USE_REG(B1REG)) u_b1 (
        .clk(CLK), .rst_n(RST_N), .ce(CEB), .rst(RSTB), .d(b1_in), .q(b1)
    );

    assign m_prod = {18'd0, a1} * {18'd0, b1};

    pipe_stage #(.WIDTH(36), .USE_REG(MREG)) u_m (
        .clk(CLK), .rst_n(RST_N), .ce(CEM), .rst(RSTM), .d(m_prod), .q(m_r)
    );

    pipe_stage #(.WIDTH(48), .USE_REG(CREG)) u_c (
        .clk(CLK), .rst_n(RST_N), .ce(CEC), .rst(RSTC), .d(C), .q(c_r)
    );

    assign cin_src = USE_CARRYIN_IN ? CARRYIN : op[5];

    pipe_stage #(.WIDTH(1), .USE_REG(CARRYINREG)) u_cin (
        .clk(CLK), .rst_n(RST_N), .ce(CECARRYIN), .rst(RSTCARRYIN), .d(cin_src), .q(cin)
    );

    // X operand select; feedback uses the live P register so accumulation runs every cycle
    always_comb begin
        x_mux = '0;
        case (op[1:0])
            2'd0: x_mux = '0;
            2'd1: x_mux = {12'd0, m_r};
            2'd2: x_mux = p_r;
            2'd3: x_mux = {d_r[11:0], a1, b1};
            default: x_mux = '0;
        endcase
    end

    // Z operand select
    always_comb begin
        z_mux = '0;
        case (op[3:2])
            2'd0: z_mux = '0;
            2'd1: z_mux = PCIN;
            2'd2: z_mux = p_r;
            2'd3: z_mux = c_r;
            default: z_mux = '0;
        endcase
    end

    // Post-adder at 49 bits so bit 48 carries the carry/borrow out
    always_comb begin
        x_plus_cin = {1'b0, x_mux} + {48'd0, cin};
        post_sum   = op[7] ? ({1'b0, z_mux} - x_plus_cin) : ({1'b0, z_mux} + x_plus_cin);
    end

    pipe_stage #(.WIDTH(48), .USE_REG(PREG)) u_p (
        .clk(CLK), .rst_n(RST_N), .ce(CEP), .rst(RSTP), .d(post_sum[47:0]), .q(p_r)
    );

    pipe_stage #(.WIDTH(1), .USE_REG(CARRYOUTREG)) u_cout (
        .clk(CLK), .rst_n(RST_N), .ce(CECARRYIN), .rst(RSTCARRYIN), .d(post_sum[48]), .q(cout_r)
    );

    assign M         = m_r;
    assign P         = p_r;
    assign PCOUT     = p_r;
    assign BCOUT     = b1;
    assign CARRYOUT  = cout_r;
    assign CARRYOUTF = cout_r;

endmodule

// File: tb/tb_main_project.sv
// tb/tb_main_project.sv - scoreboard bench for main_project against an arithmetic reference model

module tb_main_project;

    logic        CLK;
    logic        RST_N;
    logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic [35:0] M;
    logic [47:0] P, PCOUT;
    logic [17:0] BCOUT;
    logic        CARRYOUT, CARRYOUTF;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          tag;
        logic [47:0] p;
        logic [35:0] m;
        logic [17:0] bc;
        logic        co;
        bit          chk_p;
        bit          chk_m;
        bit          chk_bc;
        bit          chk_co;
    } exp_t;

    exp_t sb_q[$];

    main_project dut (
        .CLK(CLK), .RST_N(RST_N),
        .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM), .RSTP(RSTP),
        .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
        .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN),
        .CARRYIN(CARRYIN), .OPMODE(OPMODE),
        .M(M), .P(P), .PCOUT(PCOUT), .BCOUT(BCOUT),
        .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input int tag, input string what, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s tag=%0d actual=%0h required=%0h", what, tag, act, req);
        end
    endtask

    // Monitor: compares every pending expectation against the outputs at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk_p) begin
                    check(e.tag, "P", 64'(P), 64'(e.p));
                    check(e.tag, "PCOUT", 64'(PCOUT), 64'(e.p));
                end
                if (e.chk_m)  check(e.tag, "M", 64'(M), 64'(e.m));
                if (e.chk_bc) check(e.tag, "BCOUT", 64'(BCOUT), 64'(e.bc));
                if (e.chk_co) begin
                    check(e.tag, "CARRYOUT", 64'(CARRYOUT), 64'(e.co));
                    check(e.tag, "CARRYOUTF", 64'(CARRYOUTF), 64'(e.co));
                end
            end
        end
    end

    // Queue an expectation, then step past the falling edge so the monitor consumes it
    task automatic expect_out(input int tag, input logic [47:0] p, input logic [35:0] m,
                              input logic [17:0] bc, input logic co,
                              input bit cp, input bit cm, input bit cb, input bit cc);
        exp_t e;
        e.tag = tag; e.p = p; e.m = m; e.bc = bc; e.co = co;
        e.chk_p = cp; e.chk_m = cm; e.chk_bc = cb; e.chk_co = cc;
        sb_q.push_back(e);
        @(negedge CLK);
        #1;
    endtask

    // Reference: steady-state outputs for inputs held constant (no P feedback selected)
    function automatic void model(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                                  input logic [47:0] c, input logic [47:0] pcin, input logic [7:0] op,
                                  output logic [47:0] p, output logic [35:0] m,
                                  output logic [17:0] bc, output logic co);
        longint unsigned aa, bb, dd, pre, b1v, prod, x, z, cinv, r;
        aa = 64'(a); bb = 64'(b); dd = 64'(d);
        pre  = (op[6] ? (dd - bb) : (dd + bb)) & 64'h3FFFF;
        b1v  = op[4] ? pre : bb;
        prod = aa * b1v;
        case (op[1:0])
            2'd1:    x = prod;
            2'd3:    x = ((dd & 64'hFFF) << 36) | (aa << 18) | b1v;
            default: x = 0;
        endcase
        case (op[3:2])
            2'd1:    z = 64'(pcin);
            2'd3:    z = 64'(c);
            default: z = 0;
        endcase
        cinv = op[5] ? 64'd1 : 64'd0;
        r = (op[7] ? (z - (x + cinv)) : (z + x + cinv)) & 64'h1_FFFF_FFFF_FFFF;
        p  = r[47:0];
        m  = prod[35:0];
        bc = b1v[17:0];
        co = r[48];
    endfunction

    // Apply a constant input set, let the 4-edge pipeline fill, then expect steady outputs
    task automatic run_const(input int tag, input logic [17:0] a, input logic [17:0] b,
                             input logic [17:0] d, input logic [47:0] c, input logic [47:0] pcin,
                             input logic [7:0] op);
        logic [47:0] p; logic [35:0] m; logic [17:0] bc; logic co;
        A = a; B = b; D = d; C = c; PCIN = pcin; OPMODE = op;
        CARRYIN = 1'($urandom_range(0, 1));
        BCIN = 18'($urandom);
        model(a, b, d, c, pcin, op, p, m, bc, co);
        repeat (4) @(posedge CLK);
        #1;
        expect_out(tag, p, m, bc, co, 1, 1, 1, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog tag=0 actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] op;
        int xs, zs;
        RST_N = 1'b0;
        {RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE} = '0;
        {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = '1;
        A = '0; B = '0; D = '0; BCIN = '0; C = '0; PCIN = '0; CARRYIN = 1'b0; OPMODE = '0;

        // Global reset holds everything at zero despite random inputs and a running clock
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            A = 18'($urandom); B = 18'($urandom); D = 18'($urandom); BCIN = 18'($urandom);
            C = {16'($urandom), 32'($urandom)}; PCIN = {16'($urandom), 32'($urandom)};
            CARRYIN = 1'($urandom_range(0, 1)); OPMODE = 8'($urandom);
            repeat (3) @(posedge CLK);
            #1;
            expect_out(1 + i, '0, '0, '0, 1'b0, 1, 1, 1, 1);
        end

        // Release global reset with RSTP held: P stays 0 while the rest of the pipe runs
        A = 18'd2; B = 18'd3; D = 18'd4; C = 48'd5; PCIN = '0; OPMODE = 8'h1D;
        RSTP = 1'b1;
        RST_N = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        expect_out(3, '0, 36'd14, 18'd7, 1'b0, 1, 1, 1, 1);
        RSTP = 1'b0;

        // Directed arithmetic cases
        run_const(10, 18'd2, 18'd3, 18'd4, 48'd5, 48'd0, 8'h1D);
        run_const(11, 18'd2, 18'd3, 18'd4, 48'd5, 48'd0, 8'h5D);
        run_const(12, 18'd2, 18'd3, 18'd4, 48'd5, 48'd0, 8'h9D);
        run_const(13, 18'h3FFFF, 18'd1, 18'h00ABC, 48'd0, 48'd0, 8'h0F);
        run_const(14, 18'h3FFFF, 18'h3FFFF, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 8'h3D);
        run_const(15, 18'd1, 18'd5, 18'd2, 48'd0, 48'd7, 8'hD5);

        // Sync clear of M with CEM=1: reset wins
        run_const(16, 18'd2, 18'd3, 18'd4, 48'd5, 48'd0, 8'h1D);
        RSTM = 1'b1;
        @(posedge CLK); #1;
        expect_out(17, '0, '0, '0, 1'b0, 0, 1, 0, 0);
        RSTM = 1'b0;

        // Randomized operations without P feedback
        for (int i = 0; i < 24; i++) begin
            xs = int'($urandom_range(0, 2)); if (xs == 2) xs = 3;
            zs = int'($urandom_range(0, 2)); if (zs == 2) zs = 3;
            op = {4'($urandom), 2'(zs), 2'(xs)};
            run_const(100 + i, 18'($urandom), 18'($urandom), 18'($urandom),
                      {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, op);
        end

        // Accumulation: fill the pipe with X=Z=0, then P grows by 2*(4+3) per cycle
        run_const(200, 18'd2, 18'd3, 18'd4, 48'd0, 48'd0, 8'h10);
        OPMODE = 8'h19;
        for (int n = 1; n <= 8; n++) begin
            @(posedge CLK); #1;
            expect_out(200 + n, 48'(14 * (n - 1)), 36'd14, 18'd7, 1'b0, 1, 1, 1, 0);
        end
        CEP = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge CLK); #1;
            expect_out(210 + n, 48'd98, 36'd14, 18'd7, 1'b0, 1, 0, 0, 0);
        end
        CEP = 1'b1;
        @(posedge CLK); #1;
        expect_out(213, 48'd112, 36'd14, 18'd7, 1'b0, 1, 0, 0, 0);

        // CEM=0 holds M across toggling clocks while A changes
        CEM = 1'b0;
        A = 18'd5;
        repeat (3) @(posedge CLK);
        #1;
        expect_out(214, '0, 36'd14, '0, 1'b0, 0, 1, 0, 0);
        CEM = 1'b1;
        A = 18'd2;

        // Async reset mid-accumulation clears immediately; accumulation restarts from 0
        RST_N = 1'b0;
        #2;
        expect_out(220, '0, '0, '0, 1'b0, 1, 1, 1, 1);
        RST_N = 1'b1;
        @(posedge CLK); #1; expect_out(221, 48'd0,  '0, 18'd3, 1'b0, 1, 1, 1, 0);
        @(posedge CLK); #1; expect_out(222, 48'd0,  36'd6, 18'd7, 1'b0, 1, 1, 1, 0);
        @(posedge CLK); #1; expect_out(223, 48'd6,  36'd14, 18'd7, 1'b0, 1, 1, 1, 0);
        @(posedge CLK); #1; expect_out(224, 48'd20, 36'd14, 18'd7, 1'b0, 1, 1, 1, 0);
        @(posedge CLK); #1; expect_out(225, 48'd34, 36'd14, 18'd7, 1'b0, 1, 1, 1, 0);

        repeat (2) @(negedge CLK);
        check(999, "scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
